// File: rtl/status_blinker_pkg.sv
// Shared encodings and defaults for the status LED blinker.
package status_blinker_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    B_ON  = 2'd0,
    B_OFF = 2'd1,
    B_GAP = 2'd2
  } bstate_e;

  // Default reset period: all ones, truncated to the counter width.
  localparam int unsigned ROLLOVER = 32'hFFFF_FFFF;

  function automatic int ch_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/status_blinker_if.sv
// Single-cycle configuration write bus for the status blinker.
interface status_blinker_if
  import status_blinker_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 24,
  parameter int BURST_W = 4
);
  localparam int CH_W = ch_width(NUM_CH);

  logic               cfg_wr;
  logic [CH_W-1:0]    cfg_ch;
  logic [1:0]         cfg_mode;
  logic [CNT_W-1:0]   cfg_period;
  logic [BURST_W-1:0] cfg_count;

  modport master (output cfg_wr, cfg_ch, cfg_mode, cfg_period, cfg_count);
  modport slave  (input  cfg_wr, cfg_ch, cfg_mode, cfg_period, cfg_count);

endinterface

// File: rtl/status_blinker_channel.sv
// One LED channel: period counter, blink phase and burst FSM.
module blink_channel
  import status_blinker_pkg::*;
#(
  parameter int               CNT_W      = 24,
  parameter int               BURST_W    = 4,
  parameter int               GAP_TICKS  = 4,
  parameter logic [CNT_W-1:0] RST_PERIOD = CNT_W'(ROLLOVER)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               wr,
  input  mode_e              cfg_mode,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [BURST_W-1:0] cfg_count,
  output logic               led
);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  mode_e              mode;
  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   cnt;
  logic [BURST_W-1:0] count;
  logic [BURST_W-1:0] remaining, remaining_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic               phase;
  bstate_e            state, state_nxt;
  logic               tick;

  assign tick = en && (cnt == period);

  // state register; a config write or a disabled block restarts the pattern
  always_ff @(posedge clk) begin
    if (rst) begin
      mode      <= MODE_BLINK;
      period    <= RST_PERIOD;
      count     <= BURST_W'(1);
      cnt       <= '0;
      phase     <= 1'b0;
      state     <= B_ON;
      remaining <= BURST_W'(1);
      gap_cnt   <= '0;
    end else begin
      if (wr) begin
        mode   <= cfg_mode;
        period <= cfg_period;
        count  <= cfg_count;
      end
      cnt       <= (!en || wr || tick) ? '0 : cnt + CNT_W'(1);
      phase     <= (!en || wr) ? 1'b0 : (phase ^ tick);
      state     <= state_nxt;
      remaining <= remaining_nxt;
      gap_cnt   <= gap_nxt;
    end
  end

  // burst next-state
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    gap_nxt       = gap_cnt;
    if (wr) begin
      state_nxt     = B_ON;
      remaining_nxt = cfg_count;
      gap_nxt       = '0;
    end else if (!en) begin
      state_nxt     = B_ON;
      remaining_nxt = count;
      gap_nxt       = '0;
    end else if (tick) begin
      case (state)
        B_ON: begin
          state_nxt     = B_OFF;
          remaining_nxt = remaining - BURST_W'(1);
        end
        B_OFF: begin
          state_nxt = (remaining != '0) ? B_ON : B_GAP;
          gap_nxt   = '0;
        end
        B_GAP: begin
          if (gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
            state_nxt     = B_ON;
            remaining_nxt = count;
            gap_nxt       = '0;
          end else begin
            gap_nxt = gap_cnt + GAP_W'(1);
          end
        end
        default: state_nxt = B_ON;
      endcase
    end
  end

  // led output; a burst of zero flashes stays dark
  always_comb begin
    led = 1'b0;
    if (en) begin
      case (mode)
        MODE_ON:    led = 1'b1;
        MODE_BLINK: led = phase;
        MODE_BURST: led = (count != '0) && (state == B_ON);
        default:    led = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/status_blinker.sv
// Multi-channel status LED driver: enable synchroniser, config decode, channel array.
module status_blinker
  import status_blinker_pkg::*;
#(
  parameter int               NUM_CH     = 4,
  parameter int               CNT_W      = 24,
  parameter int               BURST_W    = 4,
  parameter int               GAP_TICKS  = 4,
  parameter logic [CNT_W-1:0] RST_PERIOD = CNT_W'(ROLLOVER)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  status_blinker_if.slave   cfg,
  output logic [NUM_CH-1:0] led,
  output logic              enabled
);
  logic sync1;

  // enable comes from another domain (e.g. PLL lock)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      enabled <= 1'b0;
    end else begin
      sync1   <= enable;
      enabled <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = cfg.cfg_wr && (int'(cfg.cfg_ch) < NUM_CH) && (int'(cfg.cfg_ch) == i);

    blink_channel #(
      .CNT_W      (CNT_W),
      .BURST_W    (BURST_W),
      .GAP_TICKS  (GAP_TICKS),
      .RST_PERIOD (RST_PERIOD)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (enabled),
      .wr         (sel),
      .cfg_mode   (mode_e'(cfg.cfg_mode)),
      .cfg_period (cfg.cfg_period),
      .cfg_count  (cfg.cfg_count),
      .led        (led[i])
    );
  end

endmodule

// File: tb/tb_status_blinker.sv
// Directed bench for status_blinker: blink/burst timing, enable, config and reset.
module tb_status_blinker;
  import status_blinker_pkg::*;

  localparam int NUM_CH = 5;

  // per-cycle expected led bits from the first enabled cycle (index 0 = t0)
  localparam bit [0:23] EXP0  = 24'b0000_1111_0000_1111_0000_1111; // BLINK period 3
  localparam bit [0:23] EXP1  = 24'b1100_1100_0000_0000_1100_1100; // BURST period 1 count 2
  localparam bit [0:23] EXP2  = 24'b0000_0011_1111_0000_0011_1111; // BLINK period 5
  localparam bit [0:23] EXP2W = 24'b0000_0001_0101_0101_0101_0101; // period 0 written at t5

  logic              clk;
  logic              rst;
  logic              enable;
  logic [NUM_CH-1:0] led;
  logic              enabled;
  int                n_chk;
  int                n_pass;

  status_blinker_if #(.NUM_CH(NUM_CH)) cfg ();

  status_blinker #(
    .NUM_CH     (NUM_CH),
    .RST_PERIOD (24'd5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .cfg     (cfg),
    .led     (led),
    .enabled (enabled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [4:0] exp_led(input int t, input bit alt);
    return {EXP2[t], EXP2[t], alt ? EXP2W[t] : EXP2[t], EXP1[t], EXP0[t]};
  endfunction

  task automatic cfg_write(input int ch, input logic [1:0] mode, input int period, input int count);
    cfg.cfg_wr     = 1'b1;
    cfg.cfg_ch     = 3'(ch);
    cfg.cfg_mode   = mode;
    cfg.cfg_period = 24'(period);
    cfg.cfg_count  = 4'(count);
    @(negedge clk);
    cfg.cfg_wr     = 1'b0;
  endtask

  task automatic wait_enabled(input string tag);
    enable = 1'b1;
    @(negedge clk);
    chk({tag, " sync1"}, enabled, 0);
    @(negedge clk);
    chk({tag, " sync2"}, enabled, 1);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    enable = 1'b0;
    cfg.cfg_wr = 1'b0;
    cfg.cfg_ch = '0;
    cfg.cfg_mode = 2'b00;
    cfg.cfg_period = '0;
    cfg.cfg_count = '0;
    repeat (3) @(negedge clk);
    chk("reset led", led, 0);
    chk("reset enabled", enabled, 0);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst over enable", enabled, 0);
    enable = 1'b0;
    rst = 1'b0;

    cfg_write(0, MODE_BLINK, 3, 0);
    cfg_write(1, MODE_BURST, 1, 2);
    wait_enabled("start");

    for (int t = 0; t <= 20; t++) begin
      chk($sformatf("run t%0d", t), led, exp_led(t, 1'b0));
      if (t == 20) enable = 1'b0;
      @(negedge clk);
    end
    chk("drop t21", led, exp_led(21, 1'b0));
    @(negedge clk);
    chk("drop led", led, 0);
    chk("drop enabled", enabled, 0);
    repeat (3) @(negedge clk);
    chk("off led", led, 0);

    wait_enabled("restart");
    for (int t = 0; t <= 21; t++) begin
      chk($sformatf("rerun t%0d", t), led, exp_led(t, t >= 6));
      cfg.cfg_wr     = (t == 5) || (t == 17) || (t == 18);
      cfg.cfg_ch     = (t == 5) ? 3'd2 : ((t == 17) ? 3'd5 : 3'd7);
      cfg.cfg_mode   = (t == 5) ? MODE_BLINK : MODE_ON;
      cfg.cfg_period = '0;
      cfg.cfg_count  = '0;
      @(negedge clk);
    end

    cfg_write(3, MODE_ON, 0, 0);
    chk("on led3", led[3], 1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("on disabled led3", led[3], 0);
    chk("disabled all", led, 0);
    wait_enabled("on");
    chk("reenable vec", led, 5'b01010);

    rst = 1'b1;
    cfg.cfg_wr   = 1'b1;
    cfg.cfg_ch   = 3'd0;
    cfg.cfg_mode = MODE_ON;
    @(negedge clk);
    cfg.cfg_wr = 1'b0;
    chk("mid rst led", led, 0);
    chk("mid rst enabled", enabled, 0);
    rst = 1'b0;
    wait_enabled("post rst");
    for (int t = 0; t <= 13; t++) begin
      chk($sformatf("rst default t%0d", t), led, {5{EXP2[t]}});
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
